// File: rtl/seg7_scan_to_bcd.sv
// Scanned 7-segment bus receiver: decode, per-digit glitch filter, frame handshake.
// Optional decimal-point capture is built when SEG7_DP_EN is defined.
module seg7_scan_to_bcd #(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
`ifdef SEG7_DP_EN
    input  logic                    dp,
    output logic [NUM_DIGITS-1:0]   out_dp,
`endif
    output logic [4*NUM_DIGITS-1:0] out_bcd,
    output logic [NUM_DIGITS-1:0]   out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam logic [3:0]            CNT_MAX = 4'(STABLE_CNT);
    localparam logic [NUM_DIGITS-1:0] ONE     = NUM_DIGITS'(1);

    logic [3:0]                  code;
    logic                        sample;
    logic                        load;
    logic [NUM_DIGITS-1:0]       match;
    logic [NUM_DIGITS-1:0]       commit;
    logic [NUM_DIGITS-1:0]       err_reg;
    logic [NUM_DIGITS-1:0]       seen;
    logic [NUM_DIGITS-1:0][3:0]  last_code;
    logic [NUM_DIGITS-1:0][3:0]  last_nxt;
    logic [NUM_DIGITS-1:0][3:0]  cnt;
    logic [NUM_DIGITS-1:0][3:0]  cnt_nxt;
    logic [NUM_DIGITS-1:0][3:0]  digit_reg;
`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0]       last_dp;
    logic [NUM_DIGITS-1:0]       dp_reg;
`endif

    always_comb begin
        case (seg)
            7'b1111110: code = 4'd0;
            7'b0110000: code = 4'd1;
            7'b1101101: code = 4'd2;
            7'b1111001: code = 4'd3;
            7'b0110011: code = 4'd4;
            7'b1011011: code = 4'd5;
            7'b1011111: code = 4'd6;
            7'b1110000: code = 4'd7;
            7'b1111111: code = 4'd8;
            7'b1111011: code = 4'd9;
            7'b0000000: code = 4'hF;
            default:    code = 4'hE;
        endcase
    end

    // zero or multi-hot selects are bus transitions, not samples
    assign sample = (dig_sel != '0) && ((dig_sel & (dig_sel - ONE)) == '0);
    assign load   = (&seen) && (!out_valid || out_ready);

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
`ifdef SEG7_DP_EN
            match[i] = (code == last_code[i]) && (dp == last_dp[i]);
`else
            match[i] = (code == last_code[i]);
`endif
        end
    end

    always_comb begin
        last_nxt = last_code;
        cnt_nxt  = cnt;
        commit   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sample && dig_sel[i]) begin
                if (match[i]) begin
                    if (cnt[i] < CNT_MAX) begin
                        cnt_nxt[i] = cnt[i] + 4'd1;
                        commit[i]  = (cnt[i] + 4'd1 == CNT_MAX);
                    end
                end else begin
                    last_nxt[i] = code;
                    cnt_nxt[i]  = 4'd1;
                    commit[i]   = (CNT_MAX == 4'd1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_code <= {NUM_DIGITS{4'hF}};
            cnt       <= '0;
            digit_reg <= '0;
            err_reg   <= '0;
            seen      <= '0;
            out_bcd   <= '0;
            out_err   <= '0;
            out_valid <= 1'b0;
        end else begin
            last_code <= last_nxt;
            cnt       <= cnt_nxt;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (commit[i]) begin
                    digit_reg[i] <= code;
                    err_reg[i]   <= (code == 4'hE);
                end
            end
            // a same-cycle commit keeps its seen bit across a load
            seen <= (load ? '0 : seen) | commit;
            if (load) begin
                out_bcd   <= digit_reg;
                out_err   <= err_reg;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SEG7_DP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dp <= '0;
            dp_reg  <= '0;
            out_dp  <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sample && dig_sel[i] && !match[i]) begin
                    last_dp[i] <= dp;
                end
                if (commit[i]) begin
                    dp_reg[i] <= dp;
                end
            end
            if (load) begin
                out_dp <= dp_reg;
            end
        end
    end
`endif

endmodule

// File: doc/seg7_scan_to_bcd.md
Name: seg7_scan_to_bcd

Overview:
- Receive-side counterpart of the team's BCD-to-7-segment driver.
- Samples a multiplexed (scanned) 7-segment display bus: per-cycle one-hot digit select plus segment pattern {a,b,c,d,e,f,g}.
- Decodes each pattern back to BCD, filters glitches with a per-digit stability counter, and assembles complete multi-digit frames.
- Delivers frames to downstream logic (scoreboards, display-loopback checkers) over a valid/ready handshake.

Parameters:
- NUM_DIGITS, 4: number of scanned digits, legal range 1..8.
- STABLE_CNT, 3: consecutive identical samples of a digit required before commit, legal range 1..15.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- seg  input  7  segment pattern, bit6=a … bit0=g, active-high.
- dig_sel  input  NUM_DIGITS  one-hot digit select, active-high; bit i = digit i.
- out_bcd  output  4*NUM_DIGITS  frame codes; digit i at [4i+3:4i].
- out_err  output  NUM_DIGITS  per-digit illegal-pattern flag for the frame.
- out_valid  output  1  frame available.
- out_ready  input  1  downstream accepts the frame.

Behaviour:
- Reset, asynchronous, active-low: all state and outputs cleared to 0.
  - out_bcd=0, out_err=0, out_valid=0.
  - Per-digit last_code=4'hF, stable counters=0, seen mask=0.
  - Reset mid-frame discards all partial state; no frame is emitted for it.
- Decode (combinational, on seg):
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9.
  - 0000000→4'hF (blank).
  - Any other pattern→4'hE (illegal).
- Sample qualification:
  - A cycle is a sample only if dig_sel has exactly one bit set.
  - dig_sel of zero or multi-hot: cycle ignored, no state changes.
- Per-digit filter, for selected digit i:
  - If code==last_code[i]: cnt[i] increments, saturating at STABLE_CNT.
  - Otherwise: last_code[i]<=code and cnt[i]<=1.
  - Commit: on the cycle cnt[i] becomes STABLE_CNT (transition only, not while saturated):
    - digit_reg[i]<=code
    - err_reg[i]<=(code==4'hE)
    - seen[i]<=1
  - With STABLE_CNT=1, every sample whose code differs from last_code[i] commits immediately. A sample equal to last_code[i] does not re-commit, because cnt[i] is already saturated.
  - Re-committing an already-seen digit overwrites digit_reg[i]; seen[i] stays 1.
- Frame assembly:
  - Load condition: seen==all-ones AND (!out_valid OR out_ready).
  - On load: out_bcd<=digit_reg, out_err<=err_reg, out_valid<=1, seen<=0.
  - Latency: a frame loads 1 cycle after the last digit's commit cycle, unless held by backpressure.
  - Transfer occurs when out_valid && out_ready. If there is no simultaneous load, out_valid<=0 next cycle.
  - Simultaneous transfer and load: the new frame replaces the old one and out_valid stays 1.
  - Backpressure (out_valid && !out_ready): out_bcd, out_err and out_valid are held stable. Commits continue into digit_reg and seen. The next frame carries the latest committed value per digit; no intermediate frames are queued.
  - A commit and a frame load in the same cycle on the same digit: the load takes the pre-commit digit_reg, and seen[i] is set (commit wins over clear).

Optional Feature:
- Macro: SEG7_DP_EN.
- When defined:
  - Adds input dp (1 bit, decimal point, active-high).
  - Adds output out_dp (NUM_DIGITS bits).
  - dp is compared together with seg for stability: a dp change resets cnt[i] to 1.
  - dp is committed and framed alongside the code.
  - dp does not affect decoding or illegal detection.
  - out_dp resets to 0.
- When undefined: neither port exists and no dp logic is built.

Test Plan (NUM_DIGITS=4, STABLE_CNT=3):
- Scan digits 0..3 with patterns for 1,2,3,4, each held 3 cycles in order, out_ready=1 → out_bcd=16'h4321, out_err=0, out_valid high 1 cycle starting 1 cycle after digit 3's commit.
- Digit 2 shows 5 for 2 samples then 6 for 3 → no commit of 5; frame digit 2=6.
- Digit 1 shows 1010101 for 3 samples → out_bcd[7:4]=4'hE, out_err=4'b0010. Digit 0 blank 0000000 → [3:0]=4'hF, out_err[0]=0.
- dig_sel=4'b0011 or 4'b0000 inserted mid-scan → counters and frame unchanged versus the same run without those cycles.
- out_ready=0 after first frame 16'h4321; rescan as 16'h8765 → out_bcd holds 4321; raising out_ready loads 8765 in the same cycle and out_valid stays 1.
- Assert rst_n=0 after digits 0..2 committed, then release and scan 9,9,9,9 → only frame output is 16'h9999.
